// File: rtl/vga_monitor.sv
// VGA receive-side monitor: locks onto hsync/vsync frame timing, checks sync geometry,
// flags non-black blanking pixels and publishes a per-frame checksum of active pixels.
module vga_monitor #(
  parameter int unsigned H_TOTAL  = 800,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_TOTAL  = 525,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned SYNC_POL = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [3:0]  r,
  input  logic [3:0]  g,
  input  logic [3:0]  b,
  input  logic        err_clr,
  output logic        locked,
  output logic        frame_done,
  output logic [15:0] frame_sum,
  output logic [15:0] frame_cnt,
  output logic [11:0] h_period,
  output logic [10:0] v_period,
  output logic [4:0]  err
);
  localparam int unsigned HW = 12;
  localparam int unsigned VW = 11;
  localparam int unsigned SW = 16;
  localparam int unsigned EW = 5;
  localparam logic          POL   = 1'(SYNC_POL);
  localparam logic [HW-1:0] H_MAX = {HW{1'b1}};
  localparam logic [VW-1:0] V_MAX = {VW{1'b1}};
  localparam logic [HW-1:0] H_TOT = HW'(H_TOTAL);
  localparam logic [HW-1:0] H_SW  = HW'(H_SYNC);
  localparam logic [VW-1:0] V_TOT = VW'(V_TOTAL);
  localparam logic [VW-1:0] V_SW  = VW'(V_SYNC);
  localparam logic [HW-1:0] H_LO  = HW'(H_SYNC + H_BP);
  localparam logic [HW-1:0] H_HI  = HW'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [VW-1:0] V_LO  = VW'(V_SYNC + V_BP);
  localparam logic [VW-1:0] V_HI  = VW'(V_SYNC + V_BP + V_ACTIVE - 1);

  typedef enum logic [2:0] {SEARCH, H_ACQ, V_ACQ, V_CHK, LOCKED} state_t;
  state_t state, state_nxt;

  logic          h_prev, v_prev, h_run, v_run;
  logic [HW-1:0] h_pos, h_wid, h_inc, h_pos_nxt;
  logic [VW-1:0] v_pos, v_wid, v_inc, v_pos_nxt;
  logic [SW-1:0] acc;
  logic          h_act, v_act, hle, vle;
  logic          h_per_bad, h_wid_bad, v_per_bad, v_wid_bad, h_bad, v_bad;
  logic          pix_active, blank_hit, frame_evt;
  logic [11:0]   rgb;
  logic [EW-1:0] err_set;

  // Edge detection; vsync is only meaningful on hsync leading-edge samples
  assign h_act = (hsync == POL);
  assign v_act = (vsync == POL);
  assign hle   = pix_en & h_act & ~h_prev;
  assign vle   = hle & v_act & ~v_prev;
  assign rgb   = {r, g, b};

  assign h_inc     = (h_pos == H_MAX) ? H_MAX : h_pos + HW'(1);
  assign v_inc     = (v_pos == V_MAX) ? V_MAX : v_pos + VW'(1);
  assign h_pos_nxt = hle ? '0 : h_inc;
  assign v_pos_nxt = vle ? '0 : (hle ? v_inc : v_pos);

  // A pulse still running at the next leading edge never matches
  assign h_per_bad = (h_inc != H_TOT);
  assign h_wid_bad = h_run | (h_wid != H_SW);
  assign v_per_bad = (v_inc != V_TOT);
  assign v_wid_bad = v_run | (v_wid != V_SW);
  assign h_bad     = hle & (h_per_bad | h_wid_bad);
  assign v_bad     = vle & (v_per_bad | v_wid_bad);

  assign pix_active = (h_pos_nxt >= H_LO) && (h_pos_nxt <= H_HI) &&
                      (v_pos_nxt >= V_LO) && (v_pos_nxt <= V_HI);
  assign blank_hit  = pix_en & ~pix_active & (rgb != 12'h000);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SEARCH;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    err_set   = '0;
    frame_evt = 1'b0;
    case (state)
      SEARCH: if (hle) state_nxt = H_ACQ;
      H_ACQ:  if (hle && !(h_per_bad || h_wid_bad)) state_nxt = V_ACQ;
      V_ACQ: begin
        if (h_bad)    state_nxt = SEARCH;
        else if (vle) state_nxt = V_CHK;
      end
      V_CHK: begin
        if (h_bad)                state_nxt = SEARCH;
        else if (vle && !v_bad)   state_nxt = LOCKED;
      end
      LOCKED: begin
        err_set = {blank_hit, vle & v_wid_bad, vle & v_per_bad, hle & h_wid_bad, hle & h_per_bad};
        if (h_bad || v_bad) state_nxt = SEARCH;
        else if (vle)       frame_evt = 1'b1;
      end
      default: state_nxt = SEARCH;
    endcase
  end

  // Line/frame position and sync pulse measurement
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_prev   <= 1'b0;
      v_prev   <= 1'b0;
      h_run    <= 1'b0;
      v_run    <= 1'b0;
      h_pos    <= '0;
      h_wid    <= '0;
      v_pos    <= '0;
      v_wid    <= '0;
      h_period <= '0;
      v_period <= '0;
    end else if (pix_en) begin
      h_prev <= h_act;
      h_pos  <= h_pos_nxt;
      v_pos  <= v_pos_nxt;
      if (hle) begin
        h_period <= h_inc;
        h_wid    <= HW'(1);
        h_run    <= 1'b1;
        v_prev   <= v_act;
        if (vle) begin
          v_period <= v_inc;
          v_wid    <= VW'(1);
          v_run    <= 1'b1;
        end else if (v_run) begin
          if (v_act) v_wid <= (v_wid == V_MAX) ? V_MAX : v_wid + VW'(1);
          else       v_run <= 1'b0;
        end
      end else if (h_run) begin
        if (h_act) h_wid <= (h_wid == H_MAX) ? H_MAX : h_wid + HW'(1);
        else       h_run <= 1'b0;
      end
    end
  end

  // Published status, checksum and sticky errors
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      locked     <= 1'b0;
      frame_done <= 1'b0;
      frame_sum  <= '0;
      frame_cnt  <= '0;
      acc        <= '0;
      err        <= '0;
    end else begin
      locked     <= (state_nxt == LOCKED);
      frame_done <= frame_evt;
      if (pix_en) begin
        err <= (err & ~{EW{err_clr}}) | err_set;
        if (state != LOCKED || state_nxt != LOCKED) begin
          acc <= '0;
        end else if (frame_evt) begin
          frame_sum <= acc;
          frame_cnt <= frame_cnt + SW'(1);
          acc       <= '0;
        end else if (pix_active) begin
          acc <= acc + SW'(rgb);
        end
      end
    end
  end
endmodule

// File: tb/tb_vga_monitor.sv
// Bench for vga_monitor: a frame generator with fault knobs drives the DUT; a
// sample-index based reference model predicts every output on every clock.
module tb_vga_monitor;
  localparam int HT = 20, HS = 2, HBP = 2, HA = 12;
  localparam int VT = 10, VS = 1, VBP = 1, VA = 6;
  localparam logic POL = 1'b0;
  localparam int A_H0 = HS + HBP, A_H1 = HS + HBP + HA - 1;
  localparam int A_V0 = VS + VBP, A_V1 = VS + VBP + VA - 1;

  logic        clk = 1'b0;
  logic        rst, pix_en, hsync, vsync, err_clr;
  logic [3:0]  r, g, b;
  logic        locked, frame_done;
  logic [15:0] frame_sum, frame_cnt;
  logic [11:0] h_period;
  logic [10:0] v_period;
  logic [4:0]  err;

  vga_monitor #(
    .H_TOTAL(HT), .H_SYNC(HS), .H_BP(HBP), .H_ACTIVE(HA),
    .V_TOTAL(VT), .V_SYNC(VS), .V_BP(VBP), .V_ACTIVE(VA), .SYNC_POL(0)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .hsync(hsync), .vsync(vsync),
    .r(r), .g(g), .b(b), .err_clr(err_clr), .locked(locked),
    .frame_done(frame_done), .frame_sum(frame_sum), .frame_cnt(frame_cnt),
    .h_period(h_period), .v_period(v_period), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int imin(input int a, input int c);
    return (a < c) ? a : c;
  endfunction

  // Reference model: positions and widths derived from sample/line indices of leading edges
  int m_n, m_last_hle, m_h_end, m_hle_cnt, m_last_vle, m_v_end, m_state;
  bit m_prev_h, m_prev_v, m_h_run, m_v_run, m_locked, m_done;
  int m_acc, m_sum, m_cnt, m_hp, m_vp, m_err;

  task automatic model_reset();
    m_n = 0; m_last_hle = -1; m_h_end = -1; m_hle_cnt = 0; m_last_vle = -1; m_v_end = -1;
    m_state = 0; m_prev_h = 0; m_prev_v = 0; m_h_run = 0; m_v_run = 0;
    m_locked = 0; m_done = 0; m_acc = 0; m_sum = 0; m_cnt = 0; m_hp = 0; m_vp = 0; m_err = 0;
  endtask

  task automatic model_step(input logic hs, input logic vs, input logic [11:0] px, input logic clr);
    bit h_act, v_act, hle, vle, hp_bad, hw_bad, vp_bad, vw_bad, active, hmis, vmis;
    int hpos, vpos, eset;
    h_act = (hs == POL);
    hle = h_act && !m_prev_h;
    vle = 0; hp_bad = 0; hw_bad = 0; vp_bad = 0; vw_bad = 0; eset = 0; m_done = 0;
    if (hle) begin
      m_hp   = imin(m_n - m_last_hle, 4095);
      hp_bad = (m_hp != HT);
      hw_bad = m_h_run || ((m_h_end - m_last_hle) != HS);
      m_last_hle = m_n; m_h_run = 1;
      v_act = (vs == POL);
      vle = v_act && !m_prev_v;
      if (vle) begin
        m_vp   = imin(m_hle_cnt - m_last_vle, 2047);
        vp_bad = (m_vp != VT);
        vw_bad = m_v_run || ((m_v_end - m_last_vle) != VS);
        m_last_vle = m_hle_cnt; m_v_run = 1;
      end else if (m_v_run && !v_act) begin
        m_v_end = m_hle_cnt; m_v_run = 0;
      end
      m_prev_v = v_act;
      m_hle_cnt++;
    end else if (m_h_run && !h_act) begin
      m_h_end = m_n; m_h_run = 0;
    end
    hpos = imin(m_n - m_last_hle, 4095);
    vpos = imin(m_hle_cnt - 1 - m_last_vle, 2047);
    active = (hpos >= A_H0) && (hpos <= A_H1) && (vpos >= A_V0) && (vpos <= A_V1);
    hmis = hle && (hp_bad || hw_bad);
    vmis = vle && (vp_bad || vw_bad);
    case (m_state)
      0: if (hle) m_state = 1;
      1: if (hle && !hmis) m_state = 2;
      2: if (hmis) m_state = 0; else if (vle) m_state = 3;
      3: if (hmis) m_state = 0; else if (vle && !vmis) begin m_state = 4; m_acc = 0; end
      default: begin
        if (hle && hp_bad) eset |= 1;
        if (hle && hw_bad) eset |= 2;
        if (vle && vp_bad) eset |= 4;
        if (vle && vw_bad) eset |= 8;
        if (!active && px != 12'h000) eset |= 16;
        if (hmis || vmis) m_state = 0;
        else begin
          if (active) m_acc = (m_acc + int'(px)) % 65536;
          if (vle) begin
            m_sum = m_acc; m_cnt = (m_cnt + 1) % 65536; m_acc = 0; m_done = 1;
          end
        end
      end
    endcase
    m_err = (clr ? 0 : m_err) | eset;
    m_locked = (m_state == 4);
    m_prev_h = h_act;
    m_n++;
  endtask

  // Frame generator with fault knobs
  int g_h, g_v, g_len, g_next_len, g_vs_w;
  bit g_rand;
  logic [11:0] g_val, g_poke;

  task automatic gen_restart();
    g_h = 0; g_v = 0; g_len = HT; g_next_len = HT; g_poke = 12'h000;
  endtask

  task automatic gen_drive();
    bit act;
    logic [11:0] px;
    act = (g_h >= A_H0) && (g_h <= A_H1) && (g_v >= A_V0) && (g_v <= A_V1);
    if (act) px = g_rand ? 12'($urandom) : g_val;
    else     px = 12'h000;
    if (!act && g_poke != 12'h000) begin px = g_poke; g_poke = 12'h000; end
    hsync = (g_h < HS) ? POL : ~POL;
    vsync = (g_v < g_vs_w) ? POL : ~POL;
    {r, g, b} = px;
    g_h++;
    if (g_h >= g_len) begin
      g_h = 0; g_v = (g_v + 1) % VT; g_len = g_next_len; g_next_len = HT;
    end
  endtask

  bit chk_frames;
  int exp_sum_c, last_done, done_seen;

  task automatic compare_all(input string pfx);
    check({pfx, "locked"},     32'(locked),     32'(m_locked));
    check({pfx, "frame_done"}, 32'(frame_done), 32'(m_done));
    check({pfx, "frame_sum"},  32'(frame_sum),  32'(m_sum));
    check({pfx, "frame_cnt"},  32'(frame_cnt),  32'(m_cnt));
    check({pfx, "h_period"},   32'(h_period),   32'(m_hp));
    check({pfx, "v_period"},   32'(v_period),   32'(m_vp));
    check({pfx, "err"},        32'(err),        32'(m_err));
  endtask

  task automatic tick(input bit en, input bit clr);
    @(negedge clk);
    pix_en = en;
    err_clr = en & clr;
    if (en) gen_drive();
    @(posedge clk);
    if (en) model_step(hsync, vsync, {r, g, b}, err_clr);
    else    m_done = 0;
    #1;
    compare_all("");
    if (frame_done === 1'b1 && chk_frames) begin
      if (last_done >= 0) check("done_spacing", 32'(m_n - last_done), 32'd200);
      last_done = m_n;
      done_seen++;
      check("sum_const", 32'(frame_sum), 32'(exp_sum_c));
      check("cnt_seq", 32'(frame_cnt), 32'(done_seen));
    end
  endtask

  task automatic sample(input bit clr);
    tick(1'b1, clr);
    repeat (3) tick(1'b0, 1'b0);
  endtask

  task automatic run(input int n);
    repeat (n) sample(1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; pix_en = 1'b0; err_clr = 1'b0;
    #1;
    model_reset();
    compare_all("rst_");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    gen_restart();
    last_done = -1; done_seen = 0;
  endtask

  initial begin
    rst = 1'b1; pix_en = 1'b0; hsync = ~POL; vsync = ~POL;
    r = 4'h0; g = 4'h0; b = 4'h0; err_clr = 1'b0;
    g_vs_w = VS; g_rand = 0; g_val = 12'h001; chk_frames = 0; exp_sum_c = 0;
    model_reset();
    gen_restart();
    #1 compare_all("por_");
    do_reset();

    // Clean timing, dim pixels
    chk_frames = 1; exp_sum_c = 72; g_val = 12'h001;
    run(420);
    check("lock_2f1l", 32'(locked), 32'd1);
    run(600);
    check("clean_err", 32'(err), 32'd0);

    // Clean timing, full-white pixels; frame_cnt runs 1,2,3
    do_reset();
    exp_sum_c = 32696; g_val = 12'hFFF;
    run(1050);
    check("cnt_3", 32'(frame_cnt), 32'd3);
    chk_frames = 0;

    // One stretched line while locked, relock, then clear
    do_reset();
    g_val = 12'h001;
    run(500);
    check("pre_stretch_lock", 32'(locked), 32'd1);
    g_next_len = HT + 1;
    run(50);
    check("stretch_err0", 32'(err[0]), 32'd1);
    check("stretch_unlock", 32'(locked), 32'd0);
    run(500);
    check("relock", 32'(locked), 32'd1);
    check("err0_sticky", 32'(err[0]), 32'd1);
    sample(1'b1);
    check("err_clr", 32'(err), 32'd0);

    // Non-black blanking pixel while locked
    g_poke = 12'h00F;
    run(20);
    check("blank_err4", 32'(err), 32'h10);
    check("blank_keeps_lock", 32'(locked), 32'd1);

    // Two-line vsync never locks
    do_reset();
    g_vs_w = 2;
    run(1200);
    check("vs2_no_lock", 32'(locked), 32'd0);
    check("vs2_err", 32'(err), 32'd0);
    check("vs2_vperiod", 32'(v_period), 32'd10);
    g_vs_w = VS;

    // Asynchronous reset mid-frame while locked
    do_reset();
    g_rand = 1;
    run(700);
    check("pre_rst_lock", 32'(locked), 32'd1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    model_reset();
    compare_all("amid_rst_");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run(700);
    check("relock_rst", 32'(locked), 32'd1);

    // Random pixels with sporadic line-length faults, blanking pokes and clears
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(399) == 0) g_next_len = ($urandom_range(1) == 1) ? HT + 1 : HT - 1;
      if ($urandom_range(299) == 0) g_poke = 12'($urandom_range(4095, 1));
      sample($urandom_range(149) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
